// File: rtl/snake_turn_input.sv
// snake_turn_input: button front end for the snake core.
// Synchronizes and debounces the two active-low turn buttons, turns each
// press into one turn request and hands it to the core on its frame step.
// Build option: define SNAKE_TURN_QUEUE_EN to replace the single overwrite
// slot with a 2-entry FIFO of turns (oldest first, new turns dropped when full).
module snake_turn_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bt0,
    input  logic bt1,
    input  logic step,
    output logic cmd_valid,
    output logic cmd_right,
    output logic cmd_left,
    output logic pending
);

    typedef enum logic [1:0] {
        TURN_NONE  = 2'd0,
        TURN_RIGHT = 2'd1,
        TURN_LEFT  = 2'd2
    } turn_e;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    // Bit 0 is the right button (bt0), bit 1 the left button (bt1).
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] db_q, db_d;
    logic [1:0] db_dly_q, db_dly_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];

    logic [1:0] press;
    logic       evt_right;
    logic       evt_left;
    logic       evt_any;
    turn_e      evt_turn;

    turn_e      head;
    logic       buf_nonempty_d;

    logic cmd_valid_q, cmd_valid_d;
    logic cmd_right_q, cmd_right_d;
    logic cmd_left_q,  cmd_left_d;
    logic pending_q,   pending_d;

    // Two-stage synchronizer chain for the raw pins; released level is 1.
    always_comb begin
        sync1_d = {bt1, bt0};
        sync2_d = sync1_q;
    end

    // Debounce: a button level is accepted only after it has differed from
    // the current debounced level for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        db_d     = db_q;
        db_dly_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Press events are registered 1->0 transitions of the debounced level,
    // seen the cycle after the flip; simultaneous presses cancel out.
    always_comb begin
        press     = db_dly_q & ~db_q;
        evt_right = press[0] & ~press[1];
        evt_left  = press[1] & ~press[0];
        evt_any   = evt_right | evt_left;
        evt_turn  = TURN_NONE;
        if (evt_right) begin
            evt_turn = TURN_RIGHT;
        end else if (evt_left) begin
            evt_turn = TURN_LEFT;
        end
    end

`ifdef SNAKE_TURN_QUEUE_EN

    turn_e      fifo_q [2];
    turn_e      fifo_d [2];
    logic [1:0] count_q, count_d;
    logic       pop;

    // FIFO update: a step pops the oldest turn first, then an event is
    // appended if room remains, so a full FIFO still keeps a same-cycle event.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        head    = (count_q != 2'd0) ? fifo_q[0] : TURN_NONE;
        pop     = step && (count_q != 2'd0);
        if (pop) begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = TURN_NONE;
            count_d   = count_q - 2'd1;
        end
        if (evt_any && (count_d != 2'd2)) begin
            fifo_d[count_d[0]] = evt_turn;
            count_d            = count_d + 2'd1;
        end
        buf_nonempty_d = (count_d != 2'd0);
    end

    // FIFO storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= TURN_NONE;
            fifo_q[1] <= TURN_NONE;
            count_q   <= 2'd0;
        end else begin
            fifo_q  <= fifo_d;
            count_q <= count_d;
        end
    end

`else

    turn_e slot_q, slot_d;

    // Single slot: a step hands out the old contents, then any new event
    // overwrites it so the most recent press wins.
    always_comb begin
        slot_d = slot_q;
        head   = slot_q;
        if (step) begin
            slot_d = TURN_NONE;
        end
        if (evt_any) begin
            slot_d = evt_turn;
        end
        buf_nonempty_d = (slot_d != TURN_NONE);
    end

    // Slot storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= TURN_NONE;
        end else begin
            slot_q <= slot_d;
        end
    end

`endif

    // Command outputs: a step yields one registered command pulse the
    // following cycle; an empty buffer means go straight.
    always_comb begin
        cmd_valid_d = step;
        cmd_right_d = step && (head == TURN_RIGHT);
        cmd_left_d  = step && (head == TURN_LEFT);
        pending_d   = buf_nonempty_d;
    end

    // State register for synchronizers, debouncers and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            db_q        <= 2'b11;
            db_dly_q    <= 2'b11;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_right_q <= 1'b0;
            cmd_left_q  <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_dly_q    <= db_dly_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_right_q <= cmd_right_d;
            cmd_left_q  <= cmd_left_d;
            pending_q   <= pending_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_right = cmd_right_q;
    assign cmd_left  = cmd_left_q;
    assign pending   = pending_q;

    // A command never asks for both turns at once.
    a_one_hot_turn : assert property (@(posedge clk) disable iff (!rst_n)
        !(cmd_right_q && cmd_left_q));

endmodule

// File: tb/tb_snake_turn_input.sv
// Testbench for snake_turn_input with DEBOUNCE_CYCLES = 4.
// Stimulus pushes the expected {cmd_right, cmd_left} for every step into a
// scoreboard queue; a monitor pops and compares whenever cmd_valid is seen.
module tb_snake_turn_input;

    logic clk;
    logic rst_n;
    logic bt0;
    logic bt1;
    logic step;
    logic cmd_valid;
    logic cmd_right;
    logic cmd_left;
    logic pending;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb [$];

    localparam logic [1:0] EXP_R = 2'b10;
    localparam logic [1:0] EXP_L = 2'b01;
    localparam logic [1:0] EXP_S = 2'b00;

    snake_turn_input #(
        .DEBOUNCE_CYCLES(4),
        .DB_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bt0(bt0),
        .bt1(bt1),
        .step(step),
        .cmd_valid(cmd_valid),
        .cmd_right(cmd_right),
        .cmd_left(cmd_left),
        .pending(pending)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Holds the pin/step levels for a number of cycles; called and returns 1 ns after a rising edge.
    task automatic applyStimulus(input logic b0_low, input logic b1_low, input logic stp, input int cycles);
        bt0  = ~b0_low;
        bt1  = ~b1_low;
        step = stp;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issueStep(input logic [1:0] expected);
        sb.push_back(expected);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        step = 1'b0;
    endtask

    task automatic pressRight();
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
    endtask

    task automatic pressLeft();
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
    endtask

    // Monitor: every command pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && cmd_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_cmd_valid", 8'd1, 8'd0);
            end else begin
                checkOutput("cmd_turn", {6'd0, cmd_right, cmd_left}, {6'd0, sb.pop_front()});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        bt0   = 1'b1;
        bt1   = 1'b1;
        step  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset: buffer a left turn, start counting a right press, then reset mid-count.
        pressLeft();
        checkOutput("pending_before_reset", {7'd0, pending}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_cmd_valid", {7'd0, cmd_valid}, 8'd0);
        checkOutput("reset_cmd_right", {7'd0, cmd_right}, 8'd0);
        checkOutput("reset_cmd_left", {7'd0, cmd_left}, 8'd0);
        checkOutput("reset_pending", {7'd0, pending}, 8'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Held bt0: sync low after edge 2, db flips at edge 6, stored at edge 7.
        applyStimulus(1'b1, 1'b0, 1'b0, 6);
        checkOutput("pending_after_reset_edge6", {7'd0, pending}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("pending_after_reset_edge7", {7'd0, pending}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        issueStep(EXP_R);
        checkOutput("pending_after_consume", {7'd0, pending}, 8'd0);

        // Straight with nothing buffered.
        issueStep(EXP_S);

        // Bounce rejection: 3-cycle glitch ignored, then a real press.
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkOutput("pending_after_bounce", {7'd0, pending}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("pending_after_press", {7'd0, pending}, 8'd1);
        issueStep(EXP_R);
        issueStep(EXP_S);

        // Right then left before a step.
        pressRight();
        pressLeft();
`ifdef SNAKE_TURN_QUEUE_EN
        issueStep(EXP_R);
        issueStep(EXP_L);
`else
        issueStep(EXP_L);
`endif
        issueStep(EXP_S);

        // Both buttons debounced in the same cycle cancel.
        applyStimulus(1'b1, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("pending_both_cancel", {7'd0, pending}, 8'd0);
        issueStep(EXP_S);

        // Event in the same cycle as a step: old slot out first, new event next.
        pressRight();
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        sb.push_back(EXP_R);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        step = 1'b0;
        checkOutput("pending_after_same_cycle", {7'd0, pending}, 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        issueStep(EXP_L);
        issueStep(EXP_S);

        // Three presses before any step, consumed by back-to-back steps.
        pressRight();
        pressLeft();
        pressRight();
        checkOutput("pending_three_presses", {7'd0, pending}, 8'd1);
`ifdef SNAKE_TURN_QUEUE_EN
        issueStep(EXP_R);
        issueStep(EXP_L);
`else
        issueStep(EXP_R);
        issueStep(EXP_S);
`endif
        issueStep(EXP_S);
        checkOutput("pending_end", {7'd0, pending}, 8'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_turn_input.md
# snake_turn_input

Button front end for the snake game core. Synchronizes and debounces the two raw active-low push buttons (`bt0` = turn right, `bt1` = turn left), converts each press into a single turn request, and holds it until the core's frame tick consumes it. The block sits between the board pins and the snake core's frame logic. It replaces direct level sampling of the buttons with a one-turn-per-press handshake that is registered and glitch-free.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz). Must be ≥ 2.
- `DB_W`, default 20: debounce counter width. Must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `bt0`  in  1: raw right-turn button, active-low, asynchronous to `clk`.
- `bt1`  in  1: raw left-turn button, active-low, asynchronous to `clk`.
- `step`  in  1: one-cycle pulse from the core's frame tick; requests the next turn command.
- `cmd_valid`  out  1: one-cycle pulse, the cycle after `step`; qualifies `cmd_right`/`cmd_left`.
- `cmd_right`  out  1: turn right this frame. Valid only with `cmd_valid`.
- `cmd_left`  out  1: turn left this frame. Valid only with `cmd_valid`.
- `pending`  out  1: at least one turn is buffered.

## Operation
- **Sync.** Each button passes through a 2-FF synchronizer. Reset value of both FFs is 1 (released).
- **Debounce, per button.** The block keeps a debounced state `db` (reset value 1) and a counter `cnt` (reset value 0).
  - If sync ≠ `db`, `cnt` increments.
  - When `cnt` = DEBOUNCE_CYCLES−1 and sync ≠ `db`, `db` takes the sync value and `cnt` clears.
  - If sync = `db`, `cnt` clears.
- **Press event.** A press event is a `db` transition 1→0. Release (0→1) generates nothing. Holding a button yields exactly one event.
- **Event encoding.** R = right event, L = left event. If both occur in the same cycle, the two events cancel and nothing is stored.
- **Pending slot (default build).** There is one slot holding {none, R, L}.
  - A new event overwrites the slot, so the most recent press wins.
- **Step handling.** On `step`:
  - If the slot is non-empty: on the next cycle `cmd_valid`=1 and exactly one of `cmd_right`/`cmd_left` is 1. The slot clears.
  - If the slot is empty: on the next cycle `cmd_valid`=1 with `cmd_right`=`cmd_left`=0, meaning go straight.
- **Step and event in the same cycle.** `step` consumes the old slot contents. The new event is stored afterwards for the following step.
- `cmd_right` and `cmd_left` are never both 1.
- **Reset.** `rst_n` low clears everything immediately, including any event in flight:
  - outputs `cmd_valid`, `cmd_right`, `cmd_left`, `pending` = 0;
  - slot/queue empty;
  - `db`=1 and sync FFs = 1.

## Timing
- **Raw edge to `db` change.** Let sync first differ from `db` at edge t. `db` flips at edge t+DEBOUNCE_CYCLES, provided the input stays stable throughout.
- **Bounce.** A bounce of DEBOUNCE_CYCLES−1 cycles or fewer is rejected.
- **Pin to sync.** The pin-to-sync latency adds 2 cycles.
- **Event to storage.** `pending`=1 the cycle after the `db` flip.
- **Step to command.** `step` sampled at edge k → `cmd_valid`/`cmd_*` high during the cycle after edge k, for exactly 1 cycle.
- **Pending after consumption.** `pending` falls in the same cycle, unless the queue still holds an entry.
- **Back-to-back steps.** Steps in consecutive cycles are legal. Each step produces its own `cmd_valid`.

## Configuration
- **`SNAKE_TURN_QUEUE_EN` defined:** the slot becomes a 2-entry FIFO.
  - Events are appended in order.
  - An event arriving when the FIFO is full is dropped.
  - Each `step` pops the oldest entry.
  - Step + event in the same cycle with the FIFO full: pop first, then push, so the event is kept.
  - `pending` = FIFO not empty.
- **Undefined:** single overwrite slot as described under Operation.

## Test plan
Use DEBOUNCE_CYCLES=4.
- **Reset.** Assert `rst_n`=0 mid-count with `bt0` low → all outputs 0. After release, the held `bt0` still needs 4 stable synced cycles before `pending`=1.
- **Bounce rejection.** `bt0` low for 3 cycles, high, then low for 10 cycles → exactly one R event. `step` → `cmd_valid`=1, `cmd_right`=1, `cmd_left`=0 for 1 cycle.
- **Straight.** No presses, `step` pulse → `cmd_valid`=1, `cmd_right`=`cmd_left`=0.
- **Overwrite (default build).** R then L before `step` → `cmd_left`=1. A second `step` → straight.
- **Same-cycle cases.** `bt0`/`bt1` debounced in the same cycle → `pending` stays 0. Event in the same cycle as `step` → that `step` outputs the old slot; the next `step` outputs the new event.
- **`SNAKE_TURN_QUEUE_EN`.** R, L, R presses before any `step` → steps yield R, L, then straight. The third press is dropped.
